zsig_delay: RTL and testbench

Parametrised multi-channel strobe delay/skew emulator clocked by `fclk`. Each channel reproduces its input after independently programmable rise and fall delays, counted in `fclk` cycles. Per channel, pulses shorter than the delay are either suppressed (inertial mode) or passed (latched mode). It replaces fixed-delay modelling of Z80 bus strobes (`m1_n`, `rfsh_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`) with a run-time configurable, synthesizable block, so bus-skew corner cases can be swept on hardware and in simulation.

---
 rtl/zsig_delay.sv | 135 +++++++++++++
 tb/tb_zsig_delay.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/zsig_delay.sv
// Multi-channel strobe delay/skew emulator. Each channel reproduces din after
// programmable rise/fall delays, with inertial (glitch-suppressing) or latched mode.
//
// state  | meaning
// S_IDLE | dout matches the sampled input, or a zero-delay edge is copied through
// S_PEND | a transition is counting down in cnt before it is committed to dout
module zsig_delay #(
  parameter int                  CHANNELS = 6,
  parameter int                  CH_W     = 3,
  parameter int                  CNT_W    = 4,
  parameter int                  DEF_RISE = 2,
  parameter int                  DEF_FALL = 3,
  parameter logic [CHANNELS-1:0] RST_VAL  = {CHANNELS{1'b1}}
) (
  input  logic                fclk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] din,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_rise,
  input  logic [CNT_W-1:0]    cfg_fall,
  input  logic                cfg_inertial,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] sup
);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CNT_W-1:0]    rise_q  [CHANNELS];
  logic [CNT_W-1:0]    fall_q  [CHANNELS];
  logic [CHANNELS-1:0] inert_q;
  logic [CHANNELS-1:0] din_q;
  logic [CHANNELS-1:0] dout_q;
  logic [CHANNELS-1:0] dout_d;
  logic [CHANNELS-1:0] sup_q;
  logic [CHANNELS-1:0] sup_d;
  logic [CHANNELS-1:0] cfg_hit;

  // Matching against in-range indices only makes out-of-range writes no-ops.
  always_comb begin
    cfg_hit = '0;
    for (int i = 0; i < CHANNELS; i++)
      cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
  end

  always_comb begin
    logic [CNT_W-1:0] dly;
    dly    = '0;
    dout_d = dout_q;
    sup_d  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      dly        = din_q[i] ? rise_q[i] : fall_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (din_q[i] != dout_q[i]) begin
            if (dly == '0) begin
              dout_d[i] = din_q[i];
            end else begin
              cnt_d[i]   = dly - CNT_W'(1);
              state_d[i] = S_PEND;
            end
          end
        end
        S_PEND: begin
          // A reverted input cancels even when the count has just expired.
          if (inert_q[i] && (din_q[i] == dout_q[i])) begin
            state_d[i] = S_IDLE;
            sup_d[i]   = 1'b1;
          end else if (cnt_q[i] == '0) begin
            dout_d[i]  = ~dout_q[i];
            state_d[i] = S_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      din_q  <= RST_VAL;
      dout_q <= RST_VAL;
      sup_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      din_q  <= din;
      dout_q <= dout_d;
      sup_q  <= sup_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      inert_q <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        rise_q[i] <= CNT_W'(DEF_RISE);
        fall_q[i] <= CNT_W'(DEF_FALL);
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_hit[i]) begin
          rise_q[i]  <= cfg_rise;
          fall_q[i]  <= cfg_fall;
          inert_q[i] <= cfg_inertial;
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < CHANNELS; i++)
      busy[i] = (state_q[i] == S_PEND);
  end

  assign dout = dout_q;
  assign sup  = sup_q;

endmodule

// File: tb/tb_zsig_delay.sv
// Self-checking bench for zsig_delay: table of pulse vectors with hand-derived
// output windows, scoreboard queue of per-cycle expectations, plus corner sequences.
module tb_zsig_delay;

  localparam int W = 24;

  logic       fclk = 1'b0;
  logic       rst_n;
  logic [5:0] din;
  logic       cfg_we;
  logic [2:0] cfg_ch;
  logic [3:0] cfg_rise;
  logic [3:0] cfg_fall;
  logic       cfg_inertial;
  logic [5:0] dout;
  logic [5:0] busy;
  logic [5:0] sup;

  zsig_delay dut (
    .fclk(fclk), .rst_n(rst_n), .din(din), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_rise(cfg_rise), .cfg_fall(cfg_fall), .cfg_inertial(cfg_inertial),
    .dout(dout), .busy(busy), .sup(sup)
  );

  always #5 fclk = ~fclk;

  // lo/hi: dout[ch] is low for k in [lo,hi) after E0; supk: edge of the sup pulse (0 = none)
  typedef struct {
    int         ch;
    logic [3:0] r;
    logic [3:0] f;
    logic       inert;
    int         p;
    int         lo;
    int         hi;
    int         supk;
  } vec_t;

  typedef struct {
    logic [5:0] dout;
    logic [5:0] sup;
  } exp_t;

  vec_t tbl [10];
  exp_t sb [$];
  vec_t t;
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Entered and left at a negedge; the write lands on the posedge in between.
  task automatic do_cfg(input logic [2:0] ch, input logic [3:0] r, input logic [3:0] f,
                        input logic inert);
    cfg_we = 1'b1; cfg_ch = ch; cfg_rise = r; cfg_fall = f; cfg_inertial = inert;
    @(posedge fclk);
    @(negedge fclk);
    cfg_we = 1'b0;
  endtask

  task automatic step;
    @(posedge fclk);
    @(negedge fclk);
  endtask

  initial begin
    tbl[0] = '{0, 4'd2,  4'd3,  1'b1, 6,  4,  9,  0};
    tbl[1] = '{2, 4'd4,  4'd4,  1'b1, 3,  0,  0,  4};
    tbl[2] = '{2, 4'd4,  4'd4,  1'b1, 5,  5,  10, 0};
    tbl[3] = '{2, 4'd1,  4'd4,  1'b0, 3,  5,  7,  0};
    tbl[4] = '{2, 4'd4,  4'd4,  1'b1, 4,  0,  0,  5};
    tbl[5] = '{1, 4'd0,  4'd0,  1'b1, 1,  1,  2,  0};
    tbl[6] = '{3, 4'd0,  4'd0,  1'b0, 2,  1,  3,  0};
    tbl[7] = '{4, 4'd15, 4'd1,  1'b1, 2,  2,  18, 0};
    tbl[8] = '{5, 4'd1,  4'd15, 1'b0, 2,  16, 18, 0};
    tbl[9] = '{5, 4'd1,  4'd15, 1'b1, 20, 16, 22, 0};

    rst_n = 1'b0; din = 6'h3F; cfg_we = 1'b0; cfg_ch = '0;
    cfg_rise = '0; cfg_fall = '0; cfg_inertial = 1'b0;
    repeat (3) @(negedge fclk);
    rst_n = 1'b1;
    step();
    check("reset_dout", 32'(dout), 32'h3F);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_sup",  32'(sup),  32'h0);

    // Default delays on ch0: fall 3, rise 2.
    din[0] = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      step();
      check($sformatf("def_fall_busy_k%0d", k), 32'(busy[0]), 32'((k >= 1 && k <= 3) ? 1 : 0));
      check($sformatf("def_fall_dout_k%0d", k), 32'(dout[0]), 32'((k >= 4) ? 0 : 1));
    end
    din[0] = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      step();
      check($sformatf("def_rise_dout_k%0d", k), 32'(dout[0]), 32'((k >= 3) ? 1 : 0));
    end

    for (int v = 0; v < 10; v++) begin
      t = tbl[v];
      do_cfg(3'(t.ch), t.r, t.f, t.inert);
      for (int k = 0; k <= W; k++) begin
        e.dout = 6'h3F;
        e.sup  = 6'h00;
        if (t.hi != 0 && k >= t.lo && k < t.hi) e.dout[t.ch] = 1'b0;
        if (t.supk != 0 && k == t.supk) e.sup[t.ch] = 1'b1;
        sb.push_back(e);
      end
      din[t.ch] = 1'b0;
      for (int k = 0; k <= W; k++) begin
        step();
        e = sb.pop_front();
        check($sformatf("vec%0d_k%0d_dout", v, k), 32'(dout), 32'(e.dout));
        check($sformatf("vec%0d_k%0d_sup", v, k),  32'(sup),  32'(e.sup));
        if (k == t.p - 1) din[t.ch] = 1'b1;
      end
    end

    // ch1 is at rise=fall=0: toggling every cycle follows with one cycle of latency.
    prev = 1'b1;
    din[1] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step();
      check($sformatf("zero_dout_j%0d", j), 32'(dout[1]), 32'(prev));
      check($sformatf("zero_busy_j%0d", j), 32'(busy[1]), 32'h0);
      prev = din[1];
      din[1] = ~din[1];
    end
    din[1] = 1'b1;
    repeat (3) step();

    // Config write on the detection edge: old fall (2) is used, the next fall uses 7.
    do_cfg(3'd1, 4'd0, 4'd2, 1'b1);
    din[1] = 1'b0;
    step();
    cfg_we = 1'b1; cfg_ch = 3'd1; cfg_rise = 4'd0; cfg_fall = 4'd7; cfg_inertial = 1'b1;
    step();
    cfg_we = 1'b0;
    check("cfgsame_busy_k1", 32'(busy[1]), 32'h1);
    check("cfgsame_dout_k1", 32'(dout[1]), 32'h1);
    step();
    check("cfgsame_dout_k2", 32'(dout[1]), 32'h1);
    step();
    check("cfgsame_dout_k3", 32'(dout[1]), 32'h0);
    din[1] = 1'b1;
    repeat (3) step();
    din[1] = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      step();
      if (k >= 7) check($sformatf("cfgnew_dout_k%0d", k), 32'(dout[1]), 32'((k >= 8) ? 0 : 1));
    end
    din[1] = 1'b1;
    repeat (3) step();

    // Out-of-range channel write must not touch ch0 (2/3) or ch3 (0/0 latched).
    do_cfg(3'd7, 4'd9, 4'd9, 1'b0);
    din[0] = 1'b0; din[3] = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      step();
      check($sformatf("cfg7_ch3_k%0d", k), 32'(dout[3]), 32'((k >= 1) ? 0 : 1));
      check($sformatf("cfg7_ch0_k%0d", k), 32'(dout[0]), 32'((k >= 4) ? 0 : 1));
    end
    din[0] = 1'b1; din[3] = 1'b1;
    repeat (6) step();
    check("cfg7_settled", 32'(dout), 32'h3F);

    // Asynchronous reset in the middle of a pending fall on ch0.
    din[0] = 1'b0;
    step();
    step();
    check("arst_pre_busy", 32'(busy[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", 32'(dout), 32'h3F);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_sup",  32'(sup),  32'h0);
    din = 6'h3F;
    @(negedge fclk);
    rst_n = 1'b1;
    step();
    check("arst_release_dout", 32'(dout), 32'h3F);
    check("arst_release_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
